// File: rtl/fir_decim_buf.sv
// Decimating capture stage behind a 4-tap FIR adder: warm-up discard, phase-0 capture, /4 scaling, small output FIFO.
// Build option: define FIR_DECIM_ROUND_EN for round-half-up scaling instead of truncation.
module fir_decim_buf #(
    parameter int w     = 16,
    parameter int DECIM = 2,
    parameter int DEPTH = 4,
    parameter int FILL  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [w+1:0]               s_in,
    output logic [w-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW = (FILL > 0) ? $clog2(FILL+1) : 1;

    // The sum is four w-bit taps, so dividing by 4 always fits back into w bits.
    function automatic logic [w-1:0] scale(input logic [w+1:0] s);
`ifdef FIR_DECIM_ROUND_EN
        return w'((s + (w+2)'(2)) >> 2);
`else
        return w'(s >> 2);
`endif
    endfunction

    logic [WW-1:0]  warm_q, warm_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [w-1:0]   out_data_q, out_data_d;
    logic [w-1:0]   mem_q [DEPTH];
    logic [w-1:0]   mem_d [DEPTH];

    logic           eligible, capture, full, pop, push_ok;
    logic [w-1:0]   scaled;

    always_comb begin
        eligible   = (warm_q == WW'(FILL));
        capture    = eligible && (phase_q == '0);
        full       = (count_q == CW'(DEPTH));
        pop        = (count_q != '0) && out_ready;
        push_ok    = capture && (!full || pop);
        scaled     = scale(s_in);

        warm_d     = eligible ? warm_q : warm_q + WW'(1);
        phase_d    = phase_q;
        if (eligible) begin
            phase_d = (phase_q == PW'(DECIM-1)) ? '0 : phase_q + PW'(1);
        end

        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (capture & full & ~pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = scaled;
        end

        // Output register presents the post-edge head, so it holds its last value once empty.
        out_data_d = out_data_q;
        if (count_d != '0) begin
            out_data_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q     <= '0;
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            warm_q     <= warm_d;
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage is never reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed bench for fir_decim_buf at w=16, DECIM=2, DEPTH=4, FILL=5.
module tb_fir_decim_buf;
    logic        clk;
    logic        reset;
    logic [17:0] s_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

`ifdef FIR_DECIM_ROUND_EN
    localparam int EXP7 = 2;
`else
    localparam int EXP7 = 1;
`endif

    fir_decim_buf #(.w(16), .DECIM(2), .DEPTH(4), .FILL(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One reset edge then five warm-up edges; the next edge sees the first eligible sample.
    task automatic warm();
        reset     = 1'b1;
        out_ready = 1'b1;
        s_in      = '0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        reset     = 1'b1;
        s_in      = 18'd400;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_count", {29'd0, count}, 0);
        check("rst_data", {16'd0, out_data}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);

        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("warm_valid", {31'd0, out_valid}, 0);
        end
        check("warm_count", {29'd0, count}, 0);
        tick();
        check("first_valid", {31'd0, out_valid}, 1);
        check("first_data", {16'd0, out_data}, 100);
        tick();
        check("skip_valid", {31'd0, out_valid}, 0);
        check("empty_hold", {16'd0, out_data}, 100);
        tick();
        check("second_valid", {31'd0, out_valid}, 1);
        check("second_data", {16'd0, out_data}, 100);

        warm();
        s_in = 18'd4;  tick(); check("dec_d0", {16'd0, out_data}, 1);
        s_in = 18'd8;  tick(); check("dec_v1", {31'd0, out_valid}, 0);
        s_in = 18'd12; tick(); check("dec_d1", {16'd0, out_data}, 3);
        s_in = 18'd16; tick(); check("dec_v3", {31'd0, out_valid}, 0);
        s_in = 18'd20; tick(); check("dec_d2", {16'd0, out_data}, 5);

        warm();
        s_in = 18'd7;      tick(); check("round7", {16'd0, out_data}, EXP7);
        s_in = 18'd6;      tick();
        s_in = 18'd262140; tick(); check("round_max", {16'd0, out_data}, 65535);

        warm();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_in = (i % 2 == 0) ? 18'(4 * (i / 2 + 1)) : 18'd999;
            tick();
            if (i == 6) begin
                check("ovf_full_count", {29'd0, count}, 4);
                check("ovf_not_yet", {31'd0, overflow}, 0);
            end
        end
        check("ovf_count", {29'd0, count}, 4);
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_head", {16'd0, out_data}, 1);
        out_ready = 1'b1;
        s_in      = '0;
        tick(); check("drain2", {16'd0, out_data}, 2);
        tick(); check("drain3", {16'd0, out_data}, 3);
        tick(); check("drain4", {16'd0, out_data}, 4);
        check("ovf_sticky", {31'd0, overflow}, 1);

        warm();
        check("ovf_cleared", {31'd0, overflow}, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_in = (i % 2 == 0) ? 18'(4 * (i / 2 + 1)) : 18'd999;
            tick();
        end
        check("fp_count_pre", {29'd0, count}, 4);
        s_in      = 18'd20;
        out_ready = 1'b1;
        tick();
        check("fp_count", {29'd0, count}, 4);
        check("fp_ovf", {31'd0, overflow}, 0);
        check("fp_head", {16'd0, out_data}, 2);
        s_in = 18'd999;
        tick();
        check("fp_count3", {29'd0, count}, 3);
        check("fp_head3", {16'd0, out_data}, 3);

        reset = 1'b1;
        s_in  = 18'd400;
        tick();
        check("mid_count", {29'd0, count}, 0);
        check("mid_valid", {31'd0, out_valid}, 0);
        check("mid_ovf", {31'd0, overflow}, 0);
        check("mid_data", {16'd0, out_data}, 0);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rewarm_valid", {31'd0, out_valid}, 0);
        end
        tick();
        check("rewarm_first", {31'd0, out_valid}, 1);
        check("rewarm_data", {16'd0, out_data}, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
